// File: rtl/m0_pkg.sv
// Shared types and line levels for the m0 framed serial receiver.
// The state encoding is fixed at 2 bits so the debug state output stays stable
// across builds with and without the parity option.
package m0_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Line level that starts a frame (the idle line sits at 0).
    localparam logic START_LVL = 1'b1;
    // Line level a good stop bit must have.
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/m0_rx_shifter.sv
// WIDTH-bit right shifter for the receiver. New bits enter at the MSB, so after
// WIDTH shifts the first bit received (the data LSB) sits at bit 0.
module m0_rx_shifter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             sin,
    output logic [WIDTH-1:0] q
);

    // Shift one bit in from the top whenever enabled; hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {sin, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/m0_frame_rx.sv
// Framed serial-to-parallel receiver: hunts for a start bit, gathers WIDTH data
// bits LSB-first, checks the stop bit and offers the word on a valid/ready port
// backed by a single hold register.
// Optional feature macro: M0_RX_PARITY_EN adds an even-parity bit between the
// data bits and the stop bit and enables the par_err flag.
//
// Handshake: a word moves to the consumer on any clk edge where out_valid and
// out_ready are both 1. out_data is stable while out_valid is 1 and changes only
// when a new word is loaded. A new word may be loaded on the same edge the old
// one is accepted, in which case out_valid stays 1.
module m0_frame_rx
    import m0_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             sin,
    input  logic             clr_err,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun,
    output logic             par_err,
    output state_t           dbg_state
);

    localparam int              CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] shreg;

    logic start_det;   // start bit seen in IDLE
    logic shift_en;    // data bit sampled this cycle
    logic last_bit;    // final data bit sampled this cycle
    logic stop_smp;    // stop bit sampled this cycle
    logic fe_evt;      // stop bit was wrong
    logic pe_evt;      // parity mismatch found at the stop slot
    logic good;        // frame complete and clean
    logic deliver;     // clean frame loads the hold register
    logic ov_evt;      // clean frame dropped because the hold register is busy
    logic drain;       // consumer takes the held word with nothing replacing it

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    m0_rx_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .shift_en (shift_en),
        .sin      (sin),
        .q        (shreg)
    );

    // State register; a reset mid-frame simply abandons the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and per-bit strobes; nothing advances unless en is high.
    always_comb begin
        state_nxt = state;
        start_det = 1'b0;
        shift_en  = 1'b0;
        last_bit  = 1'b0;
        stop_smp  = 1'b0;
        case (state)
            IDLE: begin
                if (en && (sin == START_LVL)) begin
                    start_det = 1'b1;
                    state_nxt = DATA;
                end
            end
            DATA: begin
                if (en) begin
                    shift_en = 1'b1;
                    if (cnt == CNT_LAST) begin
                        last_bit = 1'b1;
`ifdef M0_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
            PARITY: begin
`ifdef M0_RX_PARITY_EN
                if (en) begin
                    state_nxt = STOP;
                end
`else
                state_nxt = IDLE;
`endif
            end
            STOP: begin
                if (en) begin
                    stop_smp  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

`ifdef M0_RX_PARITY_EN
    logic par_bad;

    // Capture the even-parity verdict when the parity bit is sampled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_bad <= 1'b0;
        end else if ((state == PARITY) && en) begin
            par_bad <= ^{shreg, sin};
        end
    end
`endif

    // Classify the stop slot and decide what happens to the hold register.
    always_comb begin
        fe_evt  = stop_smp && (sin != STOP_LVL);
`ifdef M0_RX_PARITY_EN
        pe_evt  = stop_smp && par_bad;
`else
        pe_evt  = 1'b0;
`endif
        good    = stop_smp && !fe_evt && !pe_evt;
        deliver = good && (!out_valid || out_ready);
        ov_evt  = good && out_valid && !out_ready;
        drain   = out_valid && out_ready && !deliver;
    end

    // Bit counter: restarts on a start bit and wraps after the last data bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (start_det) begin
            cnt <= '0;
        end else if (shift_en) begin
            cnt <= last_bit ? '0 : cnt + CNT_W'(1);
        end
    end

    // Single-entry hold register behind the valid/ready port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (deliver) begin
            out_data  <= shreg;
            out_valid <= 1'b1;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    // Sticky error flags; a new event beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (fe_evt) begin
                frame_err <= 1'b1;
            end else if (clr_err) begin
                frame_err <= 1'b0;
            end
            if (ov_evt) begin
                overrun <= 1'b1;
            end else if (clr_err) begin
                overrun <= 1'b0;
            end
        end
    end

`ifdef M0_RX_PARITY_EN
    // Parity error flag, same sticky/clear rules as the other flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_err <= 1'b0;
        end else if (pe_evt) begin
            par_err <= 1'b1;
        end else if (clr_err) begin
            par_err <= 1'b0;
        end
    end
`else
    assign par_err = 1'b0;
`endif

endmodule

// File: tb/tb_m0_frame_rx.sv
// Directed bench for m0_frame_rx (WIDTH=16, default build without parity).
module tb_m0_frame_rx;
    import m0_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0;
    logic         sin = 1'b0;
    logic         clr_err = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         busy;
    logic         frame_err;
    logic         overrun;
    logic         par_err;
    state_t       dbg_state;

    int vectors = 0;
    int miscompares = 0;

    m0_frame_rx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .sin       (sin),
        .clr_err   (clr_err),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .par_err   (par_err),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present one bit with en=1 for one clock; returns 1 ns after the edge.
    task automatic send_bit(input logic b);
        sin = b;
        en  = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Same bit, but followed by one cycle with en=0 (sin left unchanged).
    task automatic send_bit_slow(input logic b);
        send_bit(b);
        en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Idle cycles with the line low.
    task automatic idle(input int n);
        sin = 1'b0;
        en  = 1'b1;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Full frame: start, WIDTH data bits LSB-first, stop bit.
    task automatic send_frame(input logic [W-1:0] data, input logic stop_bit,
                              input logic body_rdy, input logic stop_rdy,
                              input logic stop_clr);
        out_ready = body_rdy;
        send_bit(1'b1);
        for (int i = 0; i < W; i++) begin
            send_bit(data[i]);
        end
        out_ready = stop_rdy;
        clr_err   = stop_clr;
        send_bit(stop_bit);
        clr_err   = 1'b0;
        sin       = 1'b0;
    endtask

    task automatic drain_pulse();
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
    endtask

    task automatic clr_pulse();
        clr_err = 1'b1;
        idle(1);
        clr_err = 1'b0;
    endtask

    initial begin
        logic [W-1:0] beef;
        beef = 16'hBEEF;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flags", {29'd0, frame_err, overrun, par_err}, 32'd0);
        rst = 1'b0;
        idle(2);

        // en low in IDLE with the line high must not start a frame
        sin = 1'b1;
        en  = 1'b0;
        @(posedge clk);
        #1;
        chk("en0_no_start", 32'(busy), 32'd0);
        idle(1);

        // 1: basic frame, busy mid-frame, valid on stop edge, idle afterwards
        out_ready = 1'b0;
        send_bit(1'b1);
        chk("t1_busy_start", 32'(busy), 32'd1);
        for (int i = 0; i < W; i++) begin
            send_bit(((16'hA5C3 >> i) & 16'h1) != 16'h0);
            if (i < W - 1) begin
                chk("t1_no_early_valid", 32'(out_valid), 32'd0);
            end
        end
        send_bit(1'b0);
        chk("t1_valid", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'h0000A5C3);
        chk("t1_ferr", 32'(frame_err), 32'd0);
        chk("t1_busy_after", 32'(busy), 32'd0);
        chk("t1_par_err", 32'(par_err), 32'd0);
        idle(2);
        chk("t1_hold_valid", 32'(out_valid), 32'd1);
        drain_pulse();
        chk("t1_drained", 32'(out_valid), 32'd0);

        // 2: bad stop bit, then clear; error event beats a simultaneous clear
        send_frame(16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_ferr", 32'(frame_err), 32'd1);
        chk("t2_no_valid", 32'(out_valid), 32'd0);
        chk("t2_data_kept", 32'(out_data), 32'h0000A5C3);
        clr_pulse();
        chk("t2_ferr_clr", 32'(frame_err), 32'd0);
        send_frame(16'h1234, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("t2_evt_wins", 32'(frame_err), 32'd1);
        clr_pulse();
        chk("t2_ferr_clr2", 32'(frame_err), 32'd0);

        // 3: overrun while the hold register is full
        send_frame(16'h0001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_first_valid", 32'(out_valid), 32'd1);
        chk("t3_overrun0", 32'(overrun), 32'd0);
        send_frame(16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_data_held", 32'(out_data), 32'h00000001);
        chk("t3_overrun", 32'(overrun), 32'd1);
        chk("t3_still_valid", 32'(out_valid), 32'd1);
        drain_pulse();
        chk("t3_drained", 32'(out_valid), 32'd0);
        clr_pulse();
        chk("t3_ovr_clr", 32'(overrun), 32'd0);

        // 4: delivery, then reload on the same edge the consumer accepts
        send_frame(16'h8000, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t4_data0", 32'(out_data), 32'h00008000);
        chk("t4_valid0", 32'(out_valid), 32'd1);
        send_frame(16'h7FFF, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t4_data1", 32'(out_data), 32'h00007FFF);
        chk("t4_valid1", 32'(out_valid), 32'd1);
        chk("t4_overrun", 32'(overrun), 32'd0);
        out_ready = 1'b0;

        // 5: reset partway through a frame clears everything at once
        send_bit(1'b1);
        for (int i = 0; i < 7; i++) begin
            send_bit(beef[i]);
        end
        chk("t5_busy_pre", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_data", 32'(out_data), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        chk("t5_rst_flags", {29'd0, frame_err, overrun, par_err}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(1);
        send_frame(16'h0F0F, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_data", 32'(out_data), 32'h00000F0F);
        chk("t5_valid", 32'(out_valid), 32'd1);
        drain_pulse();

        // 6: en toggling every clock stretches the frame but not the result
        send_bit_slow(1'b1);
        for (int i = 0; i < W; i++) begin
            send_bit_slow(((16'h5AA5 >> i) & 16'h1) != 16'h0);
            if (i == 3) begin
                chk("t6_busy_hold", 32'(busy), 32'd1);
            end
        end
        chk("t6_no_early_valid", 32'(out_valid), 32'd0);
        send_bit(1'b0);
        chk("t6_valid", 32'(out_valid), 32'd1);
        chk("t6_data", 32'(out_data), 32'h00005AA5);
        chk("t6_ferr", 32'(frame_err), 32'd0);
        chk("t6_busy_after", 32'(busy), 32'd0);
        idle(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
